// File: rtl/userio_pattern_seq_if.sv
// userio_pattern_seq_if: host-side pattern/control signals and pad-stage drive outputs of the
// USERIO pattern sequencer. The master modport is the host (register block or bench);
// the slave modport is the sequencer itself.

interface userio_pattern_seq_if #(
    parameter int pWIDTH = 8,
    parameter int pDEPTH = 16,
    parameter int pHOLDW = 16
);

    localparam int CW = $clog2(pDEPTH) + 1;

    // Pattern entry being pushed
    logic [pWIDTH-1:0] I_pat_data;
    logic [pWIDTH-1:0] I_pat_oe;
    logic [pHOLDW-1:0] I_pat_hold;
    logic              I_pat_wr;

    // Playback control
    logic              I_start;
    logic              I_abort;
    logic              I_loop;

    // Values driven onto the pins while not playing
    logic [pWIDTH-1:0] I_idle_data;
    logic [pWIDTH-1:0] I_idle_oe;

    // Pad-stage drive and status
    logic [pWIDTH-1:0] O_userio_drive_data;
    logic [pWIDTH-1:0] O_userio_pwdriven;
    logic              O_busy;
    logic              O_done;
    logic              O_full;
    logic [CW-1:0]     O_count;
    logic              O_overflow;

    modport master (
        output I_pat_data, I_pat_oe, I_pat_hold, I_pat_wr,
        output I_start, I_abort, I_loop,
        output I_idle_data, I_idle_oe,
        input  O_userio_drive_data, O_userio_pwdriven,
        input  O_busy, O_done, O_full, O_count, O_overflow
    );

    modport slave (
        input  I_pat_data, I_pat_oe, I_pat_hold, I_pat_wr,
        input  I_start, I_abort, I_loop,
        input  I_idle_data, I_idle_oe,
        output O_userio_drive_data, O_userio_pwdriven,
        output O_busy, O_done, O_full, O_count, O_overflow
    );

endinterface

// File: rtl/userio_pattern_seq.sv
// userio_pattern_seq: registered pattern sequencer for the USERIO pad stage.
// The host pushes {data, output-enable, hold} entries into a small FIFO; on start the entries
// are replayed with cycle-exact timing, each one driven for hold+1 cycles, back to back.
// Optional feature: define USERIO_SEQ_LOOP_EN to allow looped playback selected by I_loop
// at start; without it I_loop is ignored and playback always consumes the entries.

module userio_pattern_seq #(
    parameter int pWIDTH = 8,
    parameter int pDEPTH = 16,
    parameter int pHOLDW = 16
) (
    input  logic                usb_clk,
    input  logic                reset_n,
    userio_pattern_seq_if.slave bus
);

    localparam int AW = $clog2(pDEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(pDEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HOLD,
        ST_FINISH
    } state_t;

    typedef struct packed {
        logic [pWIDTH-1:0] data;
        logic [pWIDTH-1:0] oe;
        logic [pHOLDW-1:0] hold;
    } entry_t;

    state_t            state;
    state_t            state_next;

    // Pattern FIFO
    entry_t            mem [pDEPTH];
    entry_t            wr_entry;
    entry_t            head;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     head_idx;
    logic [CW-1:0]     count;

    // Entry currently being played and its remaining hold cycles
    logic [pWIDTH-1:0] cur_data;
    logic [pWIDTH-1:0] cur_oe;
    logic [pHOLDW-1:0] hold_cnt;

    logic              pop;          // take the head entry this cycle
    logic              pop_free;     // that pop also releases the FIFO slot
    logic              wr_ok;        // the host write is accepted this cycle
    logic              start_go;     // start accepted with a non-empty FIFO
    logic              start_empty;  // start with nothing to play
    logic              loop_active;

    // Registered outputs
    logic [pWIDTH-1:0] tgt_data;
    logic [pWIDTH-1:0] tgt_oe;
    logic [pWIDTH-1:0] drive_q;
    logic [pWIDTH-1:0] oe_q;
    logic              busy_q;
    logic              done_q;
    logic              ovf_q;

    assign wr_entry = '{data: bus.I_pat_data, oe: bus.I_pat_oe, hold: bus.I_pat_hold};
    assign head     = mem[head_idx];
    assign pop_free = pop && !loop_active;
    assign start_go = (state == ST_IDLE) && (state_next == ST_LOAD);

    // A full FIFO still accepts a write when the head is released in the same cycle;
    // looped playback owns the stored entries, so writes are refused while it runs.
    assign wr_ok = bus.I_pat_wr && !bus.I_abort && !loop_active &&
                   ((count != FULL_COUNT) || pop_free);

`ifdef USERIO_SEQ_LOOP_EN
    logic          loop_q;
    logic [AW-1:0] loop_ptr;
    logic [AW-1:0] loop_ptr_inc;

    assign loop_active  = loop_q && (state != ST_IDLE);
    assign loop_ptr_inc = loop_ptr + 1'b1;
    assign head_idx     = loop_active ? loop_ptr : rd_ptr;

    // Loop mode latch and replay pointer: walks the stored entries and wraps from the
    // newest entry back to the oldest without freeing anything.
    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            loop_q   <= 1'b0;
            loop_ptr <= '0;
        end else if (bus.I_abort) begin
            loop_q   <= 1'b0;
        end else if (start_go) begin
            loop_q   <= bus.I_loop;
            loop_ptr <= rd_ptr;
        end else if (pop && loop_active) begin
            loop_ptr <= (loop_ptr_inc == wr_ptr) ? rd_ptr : loop_ptr_inc;
        end
    end
`else
    assign loop_active = 1'b0;
    assign head_idx    = rd_ptr;
`endif

    // Pattern storage write port
    // NOTE: the entry array has no reset; validity is tracked by the pointers and count,
    // which keeps the storage mappable onto plain RAM or register files.
    always_ff @(posedge usb_clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // FIFO pointers and occupancy; abort flushes everything
    // NOTE: all sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.I_abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_free) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, pop_free})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sequencer state register
    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: when to pop the head entry and when playback ends
    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        start_empty = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.I_start) begin
                    if (count != '0) begin
                        state_next = ST_LOAD;
                    end else begin
                        start_empty = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                pop        = 1'b1;
                state_next = ST_HOLD;
            end
            ST_HOLD: begin
                // Last cycle of the current entry: chain straight into the next one if any
                if (hold_cnt == '0) begin
                    if (count != '0) begin
                        pop = 1'b1;
                    end else begin
                        state_next = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (bus.I_abort) begin
            state_next  = ST_IDLE;
            pop         = 1'b0;
            start_empty = 1'b0;
        end
    end

    // Current entry and hold counter; the counter only counts down to zero, never wraps
    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_data <= '0;
            cur_oe   <= '0;
            hold_cnt <= '0;
        end else if (pop) begin
            cur_data <= head.data;
            cur_oe   <= head.oe;
            hold_cnt <= head.hold;
        end else if ((state == ST_HOLD) && (hold_cnt != '0)) begin
            hold_cnt <= hold_cnt - 1'b1;
        end
    end

    // Pin values for the next cycle: the playing entry while holding, idle values otherwise
    always_comb begin
        tgt_data = bus.I_idle_data;
        tgt_oe   = bus.I_idle_oe;
        if ((state == ST_HOLD) && !bus.I_abort) begin
            tgt_data = cur_data;
            tgt_oe   = cur_oe;
        end
    end

    // Output registers: pins are released during reset, status is aligned with the pins
    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            drive_q <= '0;
            oe_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            drive_q <= tgt_data;
            oe_q    <= tgt_oe;
            busy_q  <= (state_next != ST_IDLE);
            done_q  <= ((state == ST_FINISH) && !bus.I_abort) || start_empty;
        end
    end

    // Sticky overflow: abort clears it first, a dropped write sets it, start clears it
    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else if (bus.I_abort) begin
            ovf_q <= 1'b0;
        end else if (bus.I_pat_wr && !wr_ok) begin
            ovf_q <= 1'b1;
        end else if (bus.I_start) begin
            ovf_q <= 1'b0;
        end
    end

    assign bus.O_userio_drive_data = drive_q;
    assign bus.O_userio_pwdriven   = oe_q;
    assign bus.O_busy              = busy_q;
    assign bus.O_done              = done_q;
    assign bus.O_full              = (count == FULL_COUNT);
    assign bus.O_count             = count;
    assign bus.O_overflow          = ovf_q;

endmodule

// File: tb/tb_userio_pattern_seq.sv
// tb_userio_pattern_seq: self-checking bench for userio_pattern_seq.
// Idle-value vectors come from a table; playback runs are checked cycle by cycle against a
// scoreboard queue filled from the entries pushed, with hand-written abort/reset/overflow
// sequences around it. Looped playback is exercised when USERIO_SEQ_LOOP_EN is defined.

module tb_userio_pattern_seq;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int HW = 8;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [W-1:0]  oe;
        logic [HW-1:0] hold;
    } pat_t;

    typedef struct packed {
        logic [W-1:0] data;
        logic [W-1:0] oe;
        logic         busy;
        logic         done;
    } exp_t;

    typedef struct packed {
        logic [W-1:0] idle_data;
        logic [W-1:0] idle_oe;
        logic [W-1:0] exp_data;
        logic [W-1:0] exp_oe;
    } idle_vec_t;

    logic usb_clk = 1'b0;
    logic reset_n = 1'b0;

    userio_pattern_seq_if #(.pWIDTH(W), .pDEPTH(D), .pHOLDW(HW)) bus ();

    userio_pattern_seq #(.pWIDTH(W), .pDEPTH(D), .pHOLDW(HW)) dut (
        .usb_clk (usb_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 usb_clk = ~usb_clk;

    int           n_checks = 0;
    int           n_pass   = 0;
    exp_t         sb_q[$];
    pat_t         pats[$];
    string        sb_tag;
    int           sb_k;
    logic [W-1:0] idle_d;
    logic [W-1:0] idle_o;
    idle_vec_t    iv[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // One clock; inputs change and outputs are sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge usb_clk);
        #1;
        bus.I_pat_wr = 1'b0;
        bus.I_start  = 1'b0;
        bus.I_abort  = 1'b0;
    endtask

    function automatic pat_t mk(input logic [W-1:0] d, input logic [W-1:0] o, input logic [HW-1:0] h);
        pat_t p;
        p.data = d;
        p.oe   = o;
        p.hold = h;
        return p;
    endfunction

    task automatic set_idle(input logic [W-1:0] d, input logic [W-1:0] o);
        idle_d          = d;
        idle_o          = o;
        bus.I_idle_data = d;
        bus.I_idle_oe   = o;
    endtask

    task automatic set_entry(input pat_t p);
        bus.I_pat_data = p.data;
        bus.I_pat_oe   = p.oe;
        bus.I_pat_hold = p.hold;
        bus.I_pat_wr   = 1'b1;
    endtask

    task automatic push_entry(input pat_t p);
        set_entry(p);
        tick();
    endtask

    task automatic load_pats();
        foreach (pats[i]) push_entry(pats[i]);
    endtask

    task automatic exp_idle(input logic b, input logic d);
        exp_t e;
        e.data = idle_d;
        e.oe   = idle_o;
        e.busy = b;
        e.done = d;
        sb_q.push_back(e);
    endtask

    // An entry is visible for hold+1 consecutive cycles
    task automatic exp_entry(input pat_t p);
        exp_t e;
        e.data = p.data;
        e.oe   = p.oe;
        e.busy = 1'b1;
        e.done = 1'b0;
        for (int i = 0; i <= int'(p.hold); i++) sb_q.push_back(e);
    endtask

    // Whole single-pass run: two idle cycles (start edge, load edge), the entries, then a done cycle
    task automatic exp_full_run();
        exp_idle(1'b1, 1'b0);
        exp_idle(1'b1, 1'b0);
        foreach (pats[i]) exp_entry(pats[i]);
        exp_idle(1'b0, 1'b1);
        exp_idle(1'b0, 1'b0);
    endtask

    task automatic begin_run(input string tag);
        sb_tag = tag;
        sb_k   = 0;
        sb_q.delete();
    endtask

    task automatic sb_step();
        exp_t e;
        e = sb_q.pop_front();
        tick();
        check($sformatf("%s[%0d].data", sb_tag, sb_k), 32'(bus.O_userio_drive_data), 32'(e.data));
        check($sformatf("%s[%0d].oe", sb_tag, sb_k), 32'(bus.O_userio_pwdriven), 32'(e.oe));
        check($sformatf("%s[%0d].busy", sb_tag, sb_k), 32'(bus.O_busy), 32'(e.busy));
        check($sformatf("%s[%0d].done", sb_tag, sb_k), 32'(bus.O_done), 32'(e.done));
        sb_k++;
    endtask

    task automatic sb_drain(input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            sb_step();
            n++;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL %s: %0d expected cycles left, cycle budget %0d exhausted", sb_tag, sb_q.size(), budget);
            sb_q.delete();
        end
    endtask

    task automatic check_idle_out(input string tag);
        check({tag, ".data"}, 32'(bus.O_userio_drive_data), 32'(idle_d));
        check({tag, ".oe"}, 32'(bus.O_userio_pwdriven), 32'(idle_o));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before the end of the test");
        $fatal(1, "watchdog");
    end

    initial begin
        iv[0] = '{idle_data: 8'h00, idle_oe: 8'hFF, exp_data: 8'h00, exp_oe: 8'hFF};
        iv[1] = '{idle_data: 8'hFF, idle_oe: 8'h00, exp_data: 8'hFF, exp_oe: 8'h00};
        iv[2] = '{idle_data: 8'h5A, idle_oe: 8'hA5, exp_data: 8'h5A, exp_oe: 8'hA5};
        iv[3] = '{idle_data: 8'h81, idle_oe: 8'h7E, exp_data: 8'h81, exp_oe: 8'h7E};

        bus.I_pat_data = '0;
        bus.I_pat_oe   = '0;
        bus.I_pat_hold = '0;
        bus.I_pat_wr   = 1'b0;
        bus.I_start    = 1'b0;
        bus.I_abort    = 1'b0;
        bus.I_loop     = 1'b0;
        set_idle(8'hA5, 8'h3C);

        // Reset: pins released and status cleared although idle inputs are non-zero
        repeat (3) @(negedge usb_clk);
        check("rst.data", 32'(bus.O_userio_drive_data), 32'h0);
        check("rst.oe", 32'(bus.O_userio_pwdriven), 32'h0);
        check("rst.busy", 32'(bus.O_busy), 32'h0);
        check("rst.done", 32'(bus.O_done), 32'h0);
        check("rst.full", 32'(bus.O_full), 32'h0);
        check("rst.count", 32'(bus.O_count), 32'h0);
        check("rst.overflow", 32'(bus.O_overflow), 32'h0);
        @(negedge usb_clk);
        reset_n = 1'b1;
        tick();
        check_idle_out("post_rst");

        // Idle values follow the inputs with one cycle of latency
        for (int i = 0; i < 4; i++) begin
            bus.I_idle_data = iv[i].idle_data;
            bus.I_idle_oe   = iv[i].idle_oe;
            tick();
            check($sformatf("idle_vec%0d.data", i), 32'(bus.O_userio_drive_data), 32'(iv[i].exp_data));
            check($sformatf("idle_vec%0d.oe", i), 32'(bus.O_userio_pwdriven), 32'(iv[i].exp_oe));
        end
        set_idle(8'hA5, 8'h3C);
        tick();

        // Basic three-entry playback with mixed hold values
        begin_run("basic");
        pats.delete();
        pats.push_back(mk(8'h01, 8'hFF, 8'd0));
        pats.push_back(mk(8'h02, 8'hFF, 8'd2));
        pats.push_back(mk(8'h04, 8'h0F, 8'd0));
        load_pats();
        check("basic.count_loaded", 32'(bus.O_count), 32'd3);
        exp_full_run();
        bus.I_start = 1'b1;
        sb_drain(100);
        check("basic.count_after", 32'(bus.O_count), 32'd0);

        // Fill past capacity, then start; a push coinciding with the first pop of a full FIFO is kept
        begin_run("full");
        pats.delete();
        for (int i = 0; i < D + 1; i++) pats.push_back(mk(W'(i + 1), ~W'(i), 8'd0));
        load_pats();
        check("full.full", 32'(bus.O_full), 32'd1);
        check("full.count", 32'(bus.O_count), 32'(D));
        check("full.overflow", 32'(bus.O_overflow), 32'd1);
        void'(pats.pop_back());
        pats.push_back(mk(8'hEE, 8'h11, 8'd1));
        exp_full_run();
        bus.I_start = 1'b1;
        sb_step();
        check("full.ovf_cleared_by_start", 32'(bus.O_overflow), 32'd0);
        set_entry(mk(8'hEE, 8'h11, 8'd1));
        sb_step();
        check("full.count_push_pop", 32'(bus.O_count), 32'(D));
        check("full.ovf_push_pop", 32'(bus.O_overflow), 32'd0);
        sb_drain(200);
        check("full.count_after", 32'(bus.O_count), 32'd0);
        check("full.full_after", 32'(bus.O_full), 32'd0);

        // Start with an empty FIFO: done pulse, never busy, pins stay idle
        bus.I_start = 1'b1;
        tick();
        check("empty.done", 32'(bus.O_done), 32'd1);
        check("empty.busy", 32'(bus.O_busy), 32'd0);
        check_idle_out("empty");
        tick();
        check("empty.done_gone", 32'(bus.O_done), 32'd0);
        check("empty.busy_after", 32'(bus.O_busy), 32'd0);

        // A second start during playback changes nothing
        begin_run("restart");
        pats.delete();
        pats.push_back(mk(8'h11, 8'hFF, 8'd2));
        pats.push_back(mk(8'h22, 8'hF0, 8'd2));
        load_pats();
        exp_full_run();
        bus.I_start = 1'b1;
        repeat (3) sb_step();
        bus.I_start = 1'b1;
        sb_drain(100);

        // Streaming: an entry pushed during playback follows with no gap
        begin_run("stream");
        pats.delete();
        pats.push_back(mk(8'h33, 8'hFF, 8'd4));
        load_pats();
        pats.push_back(mk(8'h44, 8'h0F, 8'd0));
        exp_full_run();
        bus.I_start = 1'b1;
        repeat (3) sb_step();
        set_entry(pats[1]);
        sb_drain(100);

        // Maximum hold value: held for 2^HW cycles
        begin_run("hold_max");
        pats.delete();
        pats.push_back(mk(8'h55, 8'hAA, {HW{1'b1}}));
        load_pats();
        exp_full_run();
        bus.I_start = 1'b1;
        sb_drain(400);

        // Abort during the hold of entry 2 of 4; start and write in the abort cycle are ignored
        begin_run("abort");
        pats.delete();
        pats.push_back(mk(8'h10, 8'hFF, 8'd3));
        pats.push_back(mk(8'h20, 8'hF0, 8'd3));
        pats.push_back(mk(8'h30, 8'h0F, 8'd3));
        pats.push_back(mk(8'h40, 8'h3F, 8'd3));
        load_pats();
        check("abort.count_loaded", 32'(bus.O_count), 32'd4);
        exp_idle(1'b1, 1'b0);
        exp_idle(1'b1, 1'b0);
        exp_entry(pats[0]);
        sb_q.push_back('{data: 8'h20, oe: 8'hF0, busy: 1'b1, done: 1'b0});
        bus.I_start = 1'b1;
        sb_drain(50);
        set_entry(mk(8'h99, 8'h99, 8'd0));
        bus.I_start = 1'b1;
        bus.I_abort = 1'b1;
        tick();
        check_idle_out("abort.next");
        check("abort.count", 32'(bus.O_count), 32'd0);
        check("abort.busy", 32'(bus.O_busy), 32'd0);
        check("abort.done", 32'(bus.O_done), 32'd0);
        tick();
        check_idle_out("abort.later");
        check("abort.done_later", 32'(bus.O_done), 32'd0);
        check("abort.busy_later", 32'(bus.O_busy), 32'd0);

        // Abort clears a sticky overflow and flushes a full FIFO
        pats.delete();
        for (int i = 0; i < D + 1; i++) pats.push_back(mk(W'(i), W'(i), 8'd0));
        load_pats();
        check("abort_ovf.overflow_set", 32'(bus.O_overflow), 32'd1);
        bus.I_abort = 1'b1;
        tick();
        check("abort_ovf.overflow_clr", 32'(bus.O_overflow), 32'd0);
        check("abort_ovf.count", 32'(bus.O_count), 32'd0);
        check("abort_ovf.full", 32'(bus.O_full), 32'd0);

        // Reset in the middle of playback releases the pins at once
        pats.delete();
        pats.push_back(mk(8'h66, 8'hFF, 8'd5));
        pats.push_back(mk(8'h77, 8'hFF, 8'd5));
        load_pats();
        bus.I_start = 1'b1;
        repeat (5) tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst.data", 32'(bus.O_userio_drive_data), 32'h0);
        check("midrst.oe", 32'(bus.O_userio_pwdriven), 32'h0);
        check("midrst.count", 32'(bus.O_count), 32'h0);
        check("midrst.busy", 32'(bus.O_busy), 32'h0);
        @(negedge usb_clk);
        reset_n = 1'b1;
        tick();
        check_idle_out("midrst.after");
        check("midrst.busy_after", 32'(bus.O_busy), 32'h0);

`ifdef USERIO_SEQ_LOOP_EN
        // Looped playback: A,B repeat with no gap; writes are refused; abort stops it
        begin_run("loop");
        pats.delete();
        pats.push_back(mk(8'h5A, 8'hFF, 8'd0));
        pats.push_back(mk(8'hC3, 8'h0F, 8'd0));
        load_pats();
        exp_idle(1'b1, 1'b0);
        exp_idle(1'b1, 1'b0);
        for (int i = 0; i < 50; i++) begin
            exp_entry(pats[0]);
            exp_entry(pats[1]);
        end
        bus.I_loop  = 1'b1;
        bus.I_start = 1'b1;
        sb_drain(200);
        bus.I_loop = 1'b0;
        set_entry(mk(8'h77, 8'h77, 8'd0));
        tick();
        check("loop.overflow", 32'(bus.O_overflow), 32'd1);
        check("loop.count", 32'(bus.O_count), 32'd2);
        check("loop.busy", 32'(bus.O_busy), 32'd1);
        check("loop.no_done", 32'(bus.O_done), 32'd0);
        bus.I_abort = 1'b1;
        tick();
        check_idle_out("loop.abort");
        check("loop.abort_count", 32'(bus.O_count), 32'd0);
        check("loop.abort_busy", 32'(bus.O_busy), 32'd0);
        check("loop.abort_ovf", 32'(bus.O_overflow), 32'd0);
        tick();
        check("loop.abort_done", 32'(bus.O_done), 32'd0);
`else
        // Without the loop feature I_loop has no effect: single pass, done pulses
        begin_run("noloop");
        pats.delete();
        pats.push_back(mk(8'h5A, 8'hFF, 8'd0));
        pats.push_back(mk(8'hC3, 8'h0F, 8'd0));
        load_pats();
        exp_full_run();
        bus.I_loop  = 1'b1;
        bus.I_start = 1'b1;
        sb_drain(100);
        bus.I_loop = 1'b0;
        check("noloop.count", 32'(bus.O_count), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
